// File: rtl/ff_fifo_any_depth.sv
// Flip-flop FIFO of arbitrary depth with valid/ready handshakes on both sides,
// first-word-fall-through output, fill count, almost flags and synchronous flush.
module ff_fifo_any_depth #(
    parameter int D_WIDTH      = 6,
    parameter int DEPTH        = 5,
    parameter int ALMOST_FULL  = 4,
    parameter int ALMOST_EMPTY = 1,
    localparam int C_WIDTH     = $clog2(DEPTH + 1),
    localparam int P_WIDTH     = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               up_valid,
    output logic               up_ready,
    output logic [D_WIDTH-1:0] down_data,
    output logic               down_valid,
    input  logic               down_ready,
    output logic [C_WIDTH-1:0] count,
    output logic               almost_full,
    output logic               almost_empty
);

    if (D_WIDTH < 1 || DEPTH < 2 || ALMOST_FULL < 1 || ALMOST_FULL > DEPTH ||
        ALMOST_EMPTY < 0 || ALMOST_EMPTY >= ALMOST_FULL) begin : g_param_check
        $error("ff_fifo_any_depth: illegal parameter combination");
    end

    localparam logic [C_WIDTH-1:0] DEPTH_C = C_WIDTH'(DEPTH);
    localparam logic [C_WIDTH-1:0] AF_C    = C_WIDTH'(ALMOST_FULL);
    localparam logic [C_WIDTH-1:0] AE_C    = C_WIDTH'(ALMOST_EMPTY);
    localparam logic [P_WIDTH-1:0] LAST_P  = P_WIDTH'(DEPTH - 1);

    logic [D_WIDTH-1:0] mem_reg [DEPTH];
    logic [P_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [P_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [C_WIDTH-1:0] count_reg, count_next;
    // Keeps up_ready low throughout reset without a path from rst to the output.
    logic               active_reg;
    logic               push, pop, push_eff;

    assign up_ready     = active_reg && (count_reg != DEPTH_C);
    assign down_valid   = (count_reg != '0);
    assign down_data    = mem_reg[rd_ptr_reg];
    assign count        = count_reg;
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);

    assign push     = up_valid && up_ready;
    assign pop      = down_valid && down_ready;
    assign push_eff = push && !flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push)
                wr_ptr_next = (wr_ptr_reg == LAST_P) ? '0 : wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_next = (rd_ptr_reg == LAST_P) ? '0 : rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_next = count_reg + 1'b1;
            else if (pop && !push)
                count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            active_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            active_reg <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (!rst)
                mem_reg[gi] <= '0;
            else if (push_eff && (wr_ptr_reg == P_WIDTH'(gi)))
                mem_reg[gi] <= up_data;
        end
    end

endmodule

// File: tb/tb_ff_fifo_any_depth.sv
// Directed bench for ff_fifo_any_depth: default 5-deep instance plus a
// 3-deep, 33-bit instance whose almost flags coincide with full/empty.
module tb_ff_fifo_any_depth;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [5:0]  up_data;
    logic        up_valid;
    logic        up_ready;
    logic [5:0]  down_data;
    logic        down_valid;
    logic        down_ready;
    logic [2:0]  count;
    logic        almost_full;
    logic        almost_empty;

    logic        b_flush;
    logic [32:0] b_up_data;
    logic        b_up_valid;
    logic        b_up_ready;
    logic [32:0] b_down_data;
    logic        b_down_valid;
    logic        b_down_ready;
    logic [1:0]  b_count;
    logic        b_almost_full;
    logic        b_almost_empty;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ff_fifo_any_depth #(.D_WIDTH(6), .DEPTH(5), .ALMOST_FULL(4), .ALMOST_EMPTY(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    ff_fifo_any_depth #(.D_WIDTH(33), .DEPTH(3), .ALMOST_FULL(3), .ALMOST_EMPTY(0)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .up_data(b_up_data), .up_valid(b_up_valid), .up_ready(b_up_ready),
        .down_data(b_down_data), .down_valid(b_down_valid), .down_ready(b_down_ready),
        .count(b_count), .almost_full(b_almost_full), .almost_empty(b_almost_empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0] q[$];
        int         mcount;
        int         sent;
        int         recv;
        logic       mpush, mpop;

        rst = 1'b0; flush = 1'b0; up_data = '0; up_valid = 1'b0; down_ready = 1'b0;
        b_flush = 1'b0; b_up_data = '0; b_up_valid = 1'b0; b_down_ready = 1'b0;

        // Reset held for three cycles
        tick(); tick(); tick();
        check("rst_up_ready", up_ready, 0);
        check("rst_down_valid", down_valid, 0);
        check("rst_down_data", down_data, 0);
        check("rst_count", count, 0);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_almost_full", almost_full, 0);
        rst = 1'b1;
        tick();
        check("rel_up_ready", up_ready, 1);
        check("rel_down_valid", down_valid, 0);
        check("rel_count", count, 0);
        check("rel_almost_empty", almost_empty, 1);
        check("rel_almost_full", almost_full, 0);

        // Fill 0x01..0x05 without draining
        up_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            up_data = 6'(i);
            tick();
            check("fill_count", count, i);
            check("fill_almost_full", almost_full, (i >= 4));
            check("fill_almost_empty", almost_empty, (i <= 1));
            check("fill_head", down_data, 6'h01);
            check("fill_down_valid", down_valid, 1);
        end
        check("full_up_ready", up_ready, 0);
        up_data = 6'h3F;
        tick();
        check("full_no_push_count", count, 5);

        // Drain in order
        up_valid = 1'b0; down_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            check("drain_data", down_data, i);
            tick();
            check("drain_count", count, 5 - i);
        end
        check("drained_down_valid", down_valid, 0);
        check("drained_almost_empty", almost_empty, 1);

        // Full with simultaneous request: pop only, then push+pop
        down_ready = 1'b0; up_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            up_data = 6'(8'h10 + i);
            tick();
        end
        check("refill_count", count, 5);
        up_data = 6'h20; down_ready = 1'b1;
        check("full_sim_up_ready", up_ready, 0);
        tick();
        check("full_sim_count", count, 4);
        check("full_sim_up_ready_after", up_ready, 1);
        check("full_sim_head", down_data, 6'h11);
        tick();
        check("pushpop_count", count, 4);
        check("pushpop_head", down_data, 6'h12);
        up_valid = 1'b0;
        check("tail_d0", down_data, 6'h12); tick();
        check("tail_d1", down_data, 6'h13); tick();
        check("tail_d2", down_data, 6'h14); tick();
        check("tail_d3", down_data, 6'h20); tick();
        check("tail_empty", down_valid, 0);

        // Flush drops contents and the in-flight word
        down_ready = 1'b0; up_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            up_data = 6'(i);
            tick();
        end
        check("preflush_count", count, 3);
        up_data = 6'h2A; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_count", count, 0);
        check("flush_down_valid", down_valid, 0);
        check("flush_up_ready", up_ready, 1);
        up_data = 6'h15;
        tick();
        up_valid = 1'b0;
        check("postflush_count", count, 1);
        check("postflush_data", down_data, 6'h15);
        down_ready = 1'b1;
        tick();
        check("postflush_empty", count, 0);

        // 23 words at random valid/ready against a queue model
        mcount = 0; sent = 0; recv = 0;
        for (int cyc = 0; cyc < 500 && recv < 23; cyc++) begin
            up_valid   = (sent < 23) && ($urandom_range(0, 2) != 0);
            up_data    = 6'(sent * 7 + 3);
            down_ready = ($urandom_range(0, 1) != 0);
            mpush = up_valid && (mcount != 5);
            mpop  = down_ready && (mcount != 0);
            check("rand_up_ready", up_ready, (mcount != 5));
            check("rand_down_valid", down_valid, (mcount != 0));
            check("rand_count", count, mcount);
            if (mpop) begin
                check("rand_data", down_data, q[0]);
                void'(q.pop_front());
                recv++;
            end
            if (mpush) begin
                q.push_back(up_data);
                sent++;
            end
            mcount = mcount + int'(mpush) - int'(mpop);
            tick();
        end
        up_valid = 1'b0; down_ready = 1'b0;
        check("rand_received_all", recv, 23);

        // Three-deep 33-bit instance: almost flags equal full/empty
        b_up_valid = 1'b1;
        check("b_empty_almost_empty", b_almost_empty, 1);
        for (int i = 1; i <= 3; i++) begin
            b_up_data = {1'b1, 32'hA5A5_0000 + 32'(i)};
            tick();
            check("b_fill_count", b_count, i);
            check("b_fill_almost_full", b_almost_full, (i == 3));
            check("b_fill_almost_empty", b_almost_empty, 0);
        end
        check("b_full_up_ready", b_up_ready, 0);
        b_up_valid = 1'b0; b_down_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check("b_drain_data", b_down_data, {1'b1, 32'hA5A5_0000 + 32'(i)});
            tick();
        end
        check("b_drained_almost_empty", b_almost_empty, 1);
        check("b_drained_down_valid", b_down_valid, 0);
        b_down_ready = 1'b0;

        // Reset in the middle of a transfer
        up_valid = 1'b1; up_data = 6'h07;
        tick(); tick();
        check("prerst_count", count, 2);
        rst = 1'b0;
        tick();
        check("midrst_count", count, 0);
        check("midrst_up_ready", up_ready, 0);
        check("midrst_down_data", down_data, 0);
        rst = 1'b1; up_valid = 1'b0;
        tick();
        check("postrst_up_ready", up_ready, 1);
        check("postrst_down_valid", down_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
